// File: rtl/i2s_rx_deser.sv
// I2S serial receiver: deserialises WS-framed words onto a valid/ready port.
// Frame geometry and bit order are latched at each WS edge; flags are sticky.
module i2s_rx_deser (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        en_i,
   input  logic        ws_i,
   input  logic        sd_i,
   input  logic [4:0]  cfg_word_size_i,
   input  logic [2:0]  cfg_word_num_i,
   input  logic        cfg_lsb_first_i,
   output logic [31:0] data_o,
   output logic [2:0]  word_idx_o,
   output logic        valid_o,
   input  logic        ready_i,
   output logic        overflow_o,
   output logic        frame_err_o,
   input  logic        clr_err_i
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WAIT_WS = 2'd1,
      SHIFT   = 2'd2
   } state_t;

   state_t      state_q;
   logic        ws_q;
   logic [4:0]  bit_cnt_q;
   logic [2:0]  word_cnt_q;
   logic [4:0]  size_q;
   logic [2:0]  num_q;
   logic        lsb_q;
   logic [31:0] shift_q;
   logic [31:0] data_q;
   logic [2:0]  idx_q;
   logic        valid_q;
   logic        ovf_q;
   logic        ferr_q;

   logic        ws_edge;
   logic        start;
   logic        shifting;
   logic        last_bit;
   logic        word_done;
   logic        mid_err;
   logic [31:0] shift_d;

   always_comb begin
      ws_edge   = ws_i ^ ws_q;
      start     = en_i && ws_edge && (state_q != IDLE);
      shifting  = en_i && (state_q == SHIFT);
      last_bit  = (bit_cnt_q == size_q);
      word_done = shifting && last_bit;
      // A WS edge exactly on a word boundary is a legal frame restart.
      mid_err   = shifting && ws_edge && !last_bit && (bit_cnt_q != 5'd0);
      if (lsb_q) begin
         shift_d = shift_q | (32'(sd_i) << bit_cnt_q);
      end else begin
         shift_d = {shift_q[30:0], sd_i};
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q    <= IDLE;
         ws_q       <= 1'b0;
         bit_cnt_q  <= 5'd0;
         word_cnt_q <= 3'd0;
         size_q     <= 5'd0;
         num_q      <= 3'd0;
         lsb_q      <= 1'b0;
         shift_q    <= 32'd0;
         data_q     <= 32'd0;
         idx_q      <= 3'd0;
         valid_q    <= 1'b0;
         ovf_q      <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         ws_q <= ws_i;

         if (word_done && (!valid_q || ready_i)) begin
            data_q  <= shift_d;
            idx_q   <= word_cnt_q;
            valid_q <= 1'b1;
         end else if (valid_q && ready_i) begin
            valid_q <= 1'b0;
         end

         if (word_done && valid_q && !ready_i) begin
            ovf_q <= 1'b1;
         end else if (clr_err_i) begin
            ovf_q <= 1'b0;
         end

         if (mid_err) begin
            ferr_q <= 1'b1;
         end else if (clr_err_i) begin
            ferr_q <= 1'b0;
         end

         if (!en_i) begin
            state_q    <= IDLE;
            bit_cnt_q  <= 5'd0;
            word_cnt_q <= 3'd0;
            shift_q    <= 32'd0;
         end else if (start) begin
            state_q    <= SHIFT;
            size_q     <= cfg_word_size_i;
            num_q      <= cfg_word_num_i;
            lsb_q      <= cfg_lsb_first_i;
            bit_cnt_q  <= 5'd0;
            word_cnt_q <= 3'd0;
            shift_q    <= 32'd0;
         end else begin
            unique case (state_q)
               IDLE: begin
                  state_q <= WAIT_WS;
               end
               WAIT_WS: begin
               end
               SHIFT: begin
                  if (last_bit) begin
                     shift_q   <= 32'd0;
                     bit_cnt_q <= 5'd0;
                     if (word_cnt_q == num_q) begin
                        word_cnt_q <= 3'd0;
                        state_q    <= WAIT_WS;
                     end else begin
                        word_cnt_q <= word_cnt_q + 3'd1;
                     end
                  end else begin
                     shift_q   <= shift_d;
                     bit_cnt_q <= bit_cnt_q + 5'd1;
                  end
               end
               default: begin
                  state_q <= IDLE;
               end
            endcase
         end
      end
   end

   assign data_o      = data_q;
   assign word_idx_o  = idx_q;
   assign valid_o     = valid_q;
   assign overflow_o  = ovf_q;
   assign frame_err_o = ferr_q;

endmodule

// File: tb/tb_i2s_rx_deser.sv
// Bench for i2s_rx_deser: directed I2S frames plus random frames,
// words predicted from serial-bit arithmetic and compared in order.
module tb_i2s_rx_deser;

   logic        clk = 1'b0;
   logic        rst_i;
   logic        en_i;
   logic        ws_i;
   logic        sd_i;
   logic [4:0]  cfg_word_size_i;
   logic [2:0]  cfg_word_num_i;
   logic        cfg_lsb_first_i;
   logic [31:0] data_o;
   logic [2:0]  word_idx_o;
   logic        valid_o;
   logic        ready_i;
   logic        overflow_o;
   logic        frame_err_o;
   logic        clr_err_i;

   int          n_vec = 0;
   int          n_bad = 0;
   logic        ws_lvl = 1'b0;
   logic [34:0] exp_q[$];
   logic [34:0] got_q[$];

   always #5 clk = ~clk;

   i2s_rx_deser dut (
      .clk_i           (clk),
      .rst_i           (rst_i),
      .en_i            (en_i),
      .ws_i            (ws_i),
      .sd_i            (sd_i),
      .cfg_word_size_i (cfg_word_size_i),
      .cfg_word_num_i  (cfg_word_num_i),
      .cfg_lsb_first_i (cfg_lsb_first_i),
      .data_o          (data_o),
      .word_idx_o      (word_idx_o),
      .valid_o         (valid_o),
      .ready_i         (ready_i),
      .overflow_o      (overflow_o),
      .frame_err_o     (frame_err_o),
      .clr_err_i       (clr_err_i)
   );

   task automatic check(input string tag, input logic [31:0] obs,
                        input logic [31:0] exp);
      n_vec++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Inputs applied just after a falling edge; a transfer is logged when
   // valid/ready are both high ahead of the coming rising edge.
   task automatic step(input logic sd);
      ws_i = ws_lvl;
      sd_i = sd;
      if (valid_o === 1'b1 && ready_i === 1'b1)
         got_q.push_back({word_idx_o, data_o});
      @(negedge clk);
   endtask

   function automatic logic ser_bit(input logic [31:0] w, input int size,
                                    input logic lsb, input int i);
      return lsb ? w[i] : w[size-i];
   endfunction

   function automatic logic [31:0] rand_word(input int size);
      logic [31:0] m;
      m = 32'((64'd1 << (size + 1)) - 64'd1);
      return $urandom & m;
   endfunction

   task automatic edge_step();
      ws_lvl = ~ws_lvl;
      step(1'($urandom));
   endtask

   task automatic send_word(input logic [31:0] w, input bit tog,
                            input bit push, input logic [2:0] idx);
      int size;
      size = int'(cfg_word_size_i);
      for (int i = 0; i <= size; i++) begin
         if (tog && i == size) ws_lvl = ~ws_lvl;
         step(ser_bit(w, size, cfg_lsb_first_i, i));
      end
      if (push) exp_q.push_back({idx, w});
   endtask

   task automatic check_queue(input string tag);
      check({tag, "_cnt"}, 32'(got_q.size()), 32'(exp_q.size()));
      for (int i = 0; i < exp_q.size(); i++) begin
         if (i < got_q.size()) begin
            check({tag, "_data"}, got_q[i][31:0], exp_q[i][31:0]);
            check({tag, "_idx"}, 32'(got_q[i][34:32]), 32'(exp_q[i][34:32]));
         end
      end
      got_q.delete();
      exp_q.delete();
   endtask

   task automatic cfg(input int size, input int num, input logic lsb);
      cfg_word_size_i = 5'(size);
      cfg_word_num_i  = 3'(num);
      cfg_lsb_first_i = lsb;
   endtask

   initial begin
      logic [31:0] w0;
      logic [31:0] w1;
      logic [31:0] w2;
      logic [7:0]  pat8;
      logic [4:0]  pat5;
      int          num;

      rst_i = 1'b1;
      en_i = 1'b0;
      ws_i = 1'b0;
      sd_i = 1'b0;
      ready_i = 1'b1;
      clr_err_i = 1'b0;
      cfg(15, 1, 1'b0);
      @(negedge clk);
      step(1'b0);
      check("rst_data", data_o, 32'd0);
      check("rst_idx", 32'(word_idx_o), 32'd0);
      check("rst_valid", 32'(valid_o), 32'd0);
      check("rst_ovf", 32'(overflow_o), 32'd0);
      check("rst_ferr", 32'(frame_err_o), 32'd0);
      rst_i = 1'b0;
      en_i = 1'b1;
      step(1'b0);
      step(1'b0);

      // Stereo 16-bit, MSB first.
      cfg(15, 1, 1'b0);
      edge_step();
      send_word(32'h0000A5C3, 0, 1, 3'd0);
      send_word(32'h00001234, 0, 1, 3'd1);
      step(1'b0);
      step(1'b0);
      check("s16_valid_low", 32'(valid_o), 32'd0);
      check_queue("s16");

      // Bit-order patterns.
      cfg(7, 0, 1'b1);
      pat8 = 8'b1000_0001;
      edge_step();
      for (int i = 0; i < 8; i++) step(pat8[i]);
      exp_q.push_back({3'd0, 32'h81});
      cfg(4, 0, 1'b0);
      pat5 = 5'b10110;
      edge_step();
      for (int i = 0; i < 5; i++) step(pat5[4-i]);
      exp_q.push_back({3'd0, 32'h16});
      step(1'b0);
      step(1'b0);
      check_queue("order");

      // Random frames.
      for (int f = 0; f < 12; f++) begin
         num = int'($urandom_range(3, 0));
         cfg(int'($urandom_range(31, 1)), num, 1'($urandom));
         edge_step();
         for (int w = 0; w <= num; w++)
            send_word(rand_word(int'(cfg_word_size_i)), 0, 1, 3'(w));
         step(1'b0);
         step(1'b0);
      end
      check_queue("rand");

      // WS edge coinciding with the last bit: seamless frames.
      cfg(15, 1, 1'b0);
      edge_step();
      for (int f = 0; f < 3; f++) begin
         send_word(rand_word(15), 0, 1, 3'd0);
         send_word(rand_word(15), f < 2, 1, 3'd1);
      end
      step(1'b0);
      step(1'b0);
      check_queue("seam");
      check("seam_ferr", 32'(frame_err_o), 32'd0);

      // WS edge on a word boundary mid-frame restarts the frame.
      cfg(7, 1, 1'b1);
      edge_step();
      send_word(rand_word(7), 0, 1, 3'd0);
      edge_step();
      send_word(rand_word(7), 0, 1, 3'd0);
      send_word(rand_word(7), 0, 1, 3'd1);
      step(1'b0);
      step(1'b0);
      check_queue("bound");
      check("bound_ferr", 32'(frame_err_o), 32'd0);

      // Overflow with a stalled consumer.
      cfg(7, 1, 1'b0);
      ready_i = 1'b0;
      w0 = rand_word(7) | 32'h80;
      w1 = rand_word(7);
      edge_step();
      send_word(w0, 0, 0, 3'd0);
      send_word(w1, 0, 0, 3'd1);
      check("ovf_data", data_o, w0);
      check("ovf_valid", 32'(valid_o), 32'd1);
      check("ovf_set", 32'(overflow_o), 32'd1);
      en_i = 1'b0;
      step(1'b0);
      en_i = 1'b1;
      check("en_hold_valid", 32'(valid_o), 32'd1);
      check("en_hold_data", data_o, w0);
      clr_err_i = 1'b1;
      step(1'b0);
      clr_err_i = 1'b0;
      check("ovf_clr", 32'(overflow_o), 32'd0);
      ready_i = 1'b1;
      step(1'b0);
      step(1'b0);
      check("ovf_drain", 32'(valid_o), 32'd0);
      exp_q.push_back({3'd0, w0});
      check_queue("ovf");

      // Mid-word WS edge on a 32-bit word.
      cfg(31, 0, 1'b0);
      step(1'b0);
      edge_step();
      for (int i = 0; i < 10; i++) step(1'($urandom));
      check("ferr_pre", 32'(frame_err_o), 32'd0);
      edge_step();
      check("ferr_set", 32'(frame_err_o), 32'd1);
      send_word(rand_word(31), 0, 1, 3'd0);
      step(1'b0);
      step(1'b0);
      check_queue("ferr");
      clr_err_i = 1'b1;
      step(1'b0);
      clr_err_i = 1'b0;
      check("ferr_clr", 32'(frame_err_o), 32'd0);

      // Enable dropped mid-word.
      cfg(15, 1, 1'b0);
      edge_step();
      for (int i = 0; i < 8; i++) step(1'($urandom));
      en_i = 1'b0;
      step(1'b1);
      step(1'b1);
      en_i = 1'b1;
      for (int i = 0; i < 20; i++) step(1'($urandom));
      check_queue("en_gap");
      edge_step();
      send_word(rand_word(15), 0, 1, 3'd0);
      send_word(rand_word(15), 0, 1, 3'd1);
      step(1'b0);
      step(1'b0);
      check_queue("en_after");
      check("en_ferr", 32'(frame_err_o), 32'd0);

      // Asynchronous reset mid-word with a held word and overflow.
      cfg(7, 1, 1'b0);
      ready_i = 1'b0;
      edge_step();
      send_word(rand_word(7) | 32'h1, 0, 0, 3'd0);
      send_word(rand_word(7), 0, 0, 3'd1);
      edge_step();
      for (int i = 0; i < 3; i++) step(1'($urandom));
      #2 rst_i = 1'b1;
      #1;
      check("arst_data", data_o, 32'd0);
      check("arst_idx", 32'(word_idx_o), 32'd0);
      check("arst_valid", 32'(valid_o), 32'd0);
      check("arst_ovf", 32'(overflow_o), 32'd0);
      check("arst_ferr", 32'(frame_err_o), 32'd0);
      step(1'b0);
      step(1'b0);
      rst_i = 1'b0;
      ready_i = 1'b1;
      for (int i = 0; i < 20; i++) step(1'($urandom));
      check_queue("arst_gap");
      w2 = rand_word(7);
      edge_step();
      send_word(rand_word(7), 0, 1, 3'd0);
      send_word(w2, 0, 1, 3'd1);
      step(1'b0);
      step(1'b0);
      check_queue("arst_after");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule

// File: doc/i2s_rx_deser.md
I2S_RX_DESER -- requirements
Module: i2s_rx_deser

Interface
REQ-001 The block SHALL have one clock (clk_i) and an asynchronous, active-high reset (rst_i).
REQ-002 clk_i  input  1  I2S bit clock (gated master/slave clock from the clock/WS generator); all sampling on rising edge.
REQ-003 rst_i  input  1  asynchronous active-high reset.
REQ-004 en_i  input  1  receive enable; level.
REQ-005 ws_i  input  1  word-select from the clock/WS generator or pad.
REQ-006 sd_i  input  1  serial data from pad.
REQ-007 cfg_word_size_i  input  5  bits per word minus 1 (0..31).
REQ-008 cfg_word_num_i  input  3  words per frame minus 1 (0..7).
REQ-009 cfg_lsb_first_i  input  1  1: first bit received is bit 0; 0: first bit is bit cfg_word_size.
REQ-010 data_o  output  32  received word, right-aligned, unused upper bits zero.
REQ-011 word_idx_o  output  3  index of data_o within its frame.
REQ-012 valid_o  output  1  data_o/word_idx_o valid.
REQ-013 ready_i  input  1  consumer accepts; transfer when valid_o & ready_i at a rising edge.
REQ-014 overflow_o  output  1  sticky: completed word dropped.
REQ-015 frame_err_o  output  1  sticky: WS edge arrived mid-word.
REQ-016 clr_err_i  input  1  synchronous pulse clearing both sticky flags.

Function
REQ-017 ws_q SHALL register ws_i every cycle; ws_edge = ws_i ^ ws_q.
REQ-018 States SHALL be IDLE, WAIT_WS, SHIFT.
REQ-019 IDLE -> WAIT_WS when en_i=1; any state -> IDLE when en_i=0, with the partial word discarded and no flag set.
REQ-020 WAIT_WS -> SHIFT on ws_edge; at that edge, word size, word count and bit order SHALL be latched and held for the frame.
REQ-021 The first data bit SHALL be sampled on the rising edge after the ws_edge edge (one-bit I2S delay).
REQ-022 In SHIFT, one sd_i bit per cycle; bit_cnt counts 0..size; on bit_cnt==size the word completes and bit_cnt returns to 0.
REQ-023 On completion of word word_num, state SHALL return to WAIT_WS; further bits are ignored until the next ws_edge.
REQ-024 On completion, data_o, word_idx_o and valid_o SHALL update on the same edge, so valid_o rises the cycle after the last bit is sampled.
REQ-025 Completion with valid_o=0, or valid_o=1 and ready_i=1: the new word is loaded and valid_o stays 1.
REQ-026 Completion with valid_o=1 and ready_i=0: the new word is dropped, data_o is held, and overflow_o is set.
REQ-027 valid_o=1, ready_i=1, no completion: valid_o clears next edge.
REQ-028 ws_edge in SHIFT with bit_cnt!=0: the partial word is discarded, frame_err_o is set, and a new frame starts (REQ-020/021).
REQ-029 ws_edge on the same edge a word completes: the word is delivered normally, there is no error, and a new frame starts.
REQ-030 ws_edge in SHIFT with bit_cnt==0 and the frame not complete: a new frame starts with no error.
REQ-031 clr_err_i SHALL clear the flags; a simultaneous set takes priority.
REQ-032 valid_o and data_o SHALL be unaffected by en_i deassertion.

Reset
REQ-033 On rst_i: state=IDLE; ws_q, bit_cnt, word_cnt, shift register =0; data_o=0; word_idx_o=0; valid_o=0; overflow_o=0; frame_err_o=0.
REQ-034 Reset mid-frame SHALL discard all partial data; the first frame after release requires a fresh ws_edge.

Verification
REQ-035 size=15, num=1, msb-first, ready_i=1, words 0xA5C3 and 0x1234 after ws 0->1 -> data_o=0x0000A5C3 idx0, then 0x00001234 idx1, each valid for one cycle.
REQ-036 size=7, lsb-first, serial 1,0,0,0,0,0,0,1 -> data_o=0x81; size=4, serial 1,0,1,1,0 msb-first -> data_o=0x16.
REQ-037 ready_i=0, two words complete -> first word held, overflow_o=1 after second completion; clr_err_i -> overflow_o=0.
REQ-038 size=31, ws toggles after 10 bits -> no valid_o, frame_err_o=1; next full word is received correctly.
REQ-039 en_i dropped mid-word then re-raised -> no valid_o until a new ws_edge, and the full following word is received.
REQ-040 rst_i asserted mid-word asynchronously -> all outputs 0 immediately, with no valid_o until a new ws_edge.
